// File: rtl/bfp16_accumulator.sv
// Streaming BFP16 packet reducer: sums in_last-delimited product beats into one
// BFP16 result (truncation rounding) with valid/ready handshakes on both sides.
module bfp16_accumulator #(
  parameter int unsigned CNT_W          = 8,
  parameter bit          CLEAR_ON_EMPTY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan
);

  localparam logic [15:0] QNAN = 16'h7FC0;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  function automatic logic is_nan(input logic [15:0] x);
    is_nan = (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    is_inf = (x[14:7] == 8'hFF) && (x[6:0] == 7'd0);
  endfunction

  // Returns {nan_produced, sum}. Mantissas carry 3 guard bits that are
  // truncated after normalisation.
  function automatic logic [16:0] bf_add(input logic [15:0] a, input logic [15:0] b);
    logic              a_nan, b_nan, a_inf, b_inf, swap, sl, ss;
    logic [14:0]       a_mag, b_mag;
    logic [7:0]        el, es, diff;
    logic [10:0]       ml, ms, msh, norm;
    logic [11:0]       sum;
    logic [3:0]        lz;
    logic signed [9:0] re;
    a_nan = is_nan(a);
    b_nan = is_nan(b);
    a_inf = is_inf(a);
    b_inf = is_inf(b);
    a_mag = (a[14:7] == 8'h00) ? '0 : a[14:0];
    b_mag = (b[14:7] == 8'h00) ? '0 : b[14:0];
    swap  = (b_mag > a_mag);
    sl    = swap ? b[15] : a[15];
    ss    = swap ? a[15] : b[15];
    el    = swap ? b_mag[14:7] : a_mag[14:7];
    es    = swap ? a_mag[14:7] : b_mag[14:7];
    ml    = (el == 8'h00) ? '0 : {1'b1, (swap ? b_mag[6:0] : a_mag[6:0]), 3'b000};
    ms    = (es == 8'h00) ? '0 : {1'b1, (swap ? a_mag[6:0] : b_mag[6:0]), 3'b000};
    diff  = el - es;
    msh   = (diff >= 8'd11) ? '0 : (ms >> diff);
    sum   = (sl == ss) ? ({1'b0, ml} + {1'b0, msh}) : ({1'b0, ml} - {1'b0, msh});
    lz = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (sum[i]) lz = 4'(10 - i);
    end
    if (sum[11]) begin
      norm = sum[11:1];
      re   = $signed({2'b00, el}) + 10'sd1;
    end else begin
      norm = sum[10:0] << lz;
      re   = $signed({2'b00, el}) - $signed({6'd0, lz});
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
      bf_add = {1'b1, QNAN};
    else if (a_inf)
      bf_add = {1'b0, a};
    else if (b_inf)
      bf_add = {1'b0, b};
    else if (sum == '0)
      bf_add = {1'b0, a[15] & b[15], 15'd0};
    else if (re <= 0)
      bf_add = {1'b0, sl, 15'd0};
    else if (re >= 10'sd255)
      bf_add = {1'b0, sl, 8'hFF, 7'd0};
    else
      bf_add = {1'b0, sl, re[7:0], norm[9:3]};
  endfunction

  state_t           state_q;
  logic [15:0]      acc_q, acc_d, out_data_q;
  logic [CNT_W-1:0] count_q, count_d, out_count_q;
  logic             nan_q, nan_d, out_nan_q, out_valid_q, in_ready_q;
  logic             accept;
  logic [16:0]      sum_res;

  assign accept  = in_valid && in_ready_q;
  assign sum_res = bf_add(acc_q, in_data);

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    nan_d   = nan_q;
    if (state_q == S_IDLE) begin
      acc_d   = is_nan(in_data) ? QNAN : in_data;
      nan_d   = is_nan(in_data);
      count_d = CNT_W'(1);
    end else begin
      acc_d   = sum_res[15:0];
      nan_d   = nan_q | sum_res[16];
      count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    end
  end

  // Output registers load on the last accepted beat so the result is valid
  // the cycle after, and stay frozen through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      nan_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_nan_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            nan_q   <= nan_d;
            if (in_last) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              out_data_q  <= acc_d;
              out_count_q <= count_d;
              out_nan_q   <= nan_d;
            end else begin
              state_q <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
            nan_q       <= 1'b0;
            if (CLEAR_ON_EMPTY) acc_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_bfp16_accumulator.sv
// Bench for bfp16_accumulator: directed vector table, hand-written handshake
// corner cases and random packets against an integer-arithmetic reference.
module tb_bfp16_accumulator;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_nan;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        in_ready2, out_valid2, out_nan2;
  logic [15:0] out_data2;
  logic [1:0]  out_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bfp16_accumulator #(.CNT_W(8), .CLEAR_ON_EMPTY(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_nan(out_nan)
  );

  bfp16_accumulator #(.CNT_W(2), .CLEAR_ON_EMPTY(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2),
    .out_nan(out_nan2)
  );

  typedef struct packed {
    logic [2:0]       n;
    logic [2:0][15:0] d;
    logic [15:0]      ed;
    logic [7:0]       ec;
    logic             en;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mkvec(input int n, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2, input logic [15:0] ed, input logic en);
    vec_t v;
    v.n  = 3'(n);
    v.d  = {d2, d1, d0};
    v.ed = ed;
    v.ec = 8'(n);
    v.en = en;
    return v;
  endfunction

  // Reference sum: exact integer alignment with 3 guard bits, loop normalisation.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, va, vb, ka, kb, el, es, vl, vs, d, sml, sum, e;
    bit an, bn, ai, bi, sgl, sgs;
    logic [31:0] sv;
    logic [7:0]  e8;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    an = (ea == 255) && (a[6:0] != 7'd0);
    bn = (eb == 255) && (b[6:0] != 7'd0);
    ai = (ea == 255) && (a[6:0] == 7'd0);
    bi = (eb == 255) && (b[6:0] == 7'd0);
    if (an || bn) return {1'b1, 16'h7FC0};
    if (ai && bi && (a[15] != b[15])) return {1'b1, 16'h7FC0};
    if (ai) return {1'b0, a};
    if (bi) return {1'b0, b};
    va = (ea == 0) ? 0 : 128 + int'(a[6:0]);
    vb = (eb == 0) ? 0 : 128 + int'(b[6:0]);
    ka = (va == 0) ? 0 : ea * 256 + va;
    kb = (vb == 0) ? 0 : eb * 256 + vb;
    if (ka >= kb) begin
      el = ea; vl = va; sgl = a[15]; es = eb; vs = vb; sgs = b[15];
    end else begin
      el = eb; vl = vb; sgl = b[15]; es = ea; vs = va; sgs = a[15];
    end
    d   = el - es;
    sml = (d >= 11) ? 0 : ((vs * 8) >> d);
    sum = (sgl == sgs) ? vl * 8 + sml : vl * 8 - sml;
    if (sum == 0) return {1'b0, a[15] & b[15], 15'd0};
    e = el;
    while (sum >= 2048) begin sum = sum / 2; e = e + 1; end
    while (sum < 1024) begin sum = sum * 2; e = e - 1; end
    if (e <= 0) return {1'b0, sgl, 15'd0};
    if (e >= 255) return {1'b0, sgl, 8'hFF, 7'd0};
    sv = 32'(sum);
    e8 = 8'(e);
    return {1'b0, sgl, e8, sv[9:3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input int gmax);
    int g, t;
    g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] ed, input int ec,
                           input logic en, input int hold);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_latency"}, 32'(t), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'(ed));
    check({tag, "_count"}, 32'(out_count), 32'(ec));
    check({tag, "_nan"}, 32'(out_nan), 32'(en));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) check({tag, "_held"}, 32'(out_data), 32'(ed));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [15:0] rnd_val();
    logic [31:0] r;
    logic [15:0] v;
    int k;
    r = $urandom;
    k = int'($urandom_range(0, 19));
    v = {r[15], 8'd0, r[6:0]};
    case (k)
      0: v[14:0] = {8'hFF, 7'd0};
      1: v[14:7] = 8'hFF; // NaN when frac non-zero, forced below
      2: v[14:0] = '0;
      3: v[14:7] = 8'h00;
      4: v[14:7] = 8'(250 + int'($urandom_range(0, 4)));
      default: v[14:7] = 8'(120 + int'($urandom_range(0, 15)));
    endcase
    if (k == 1) v[0] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [15:0] pk [6];
    logic [16:0] r;
    logic [15:0] acc;
    logic        nan;
    int          n, idle;

    vecs[0] = mkvec(2, 16'h3F80, 16'hBF80, 16'h0, 16'h0000, 1'b0);
    vecs[1] = mkvec(2, 16'h8000, 16'h8000, 16'h0, 16'h8000, 1'b0);
    vecs[2] = mkvec(1, 16'h3F00, 16'h0, 16'h0, 16'h3F00, 1'b0);
    vecs[3] = mkvec(2, 16'h4B80, 16'h3F80, 16'h0, 16'h4B80, 1'b0);
    vecs[4] = mkvec(3, 16'h4040, 16'hBF80, 16'h3F00, 16'h4020, 1'b0);
    vecs[5] = mkvec(2, 16'h7F7F, 16'h7F7F, 16'h0, 16'h7F80, 1'b0);
    vecs[6] = mkvec(2, 16'h7F80, 16'hFF80, 16'h0, 16'h7FC0, 1'b1);
    vecs[7] = mkvec(2, 16'h7FC1, 16'h3F80, 16'h0, 16'h7FC0, 1'b1);
    vecs[8] = mkvec(1, 16'h3F80, 16'h0, 16'h0, 16'h3F80, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_nan", 32'(out_nan), 32'd0);

    // First packet: result held stable with out_ready low.
    send_beat(16'h3F80, 1'b0, 0);
    send_beat(16'h4000, 1'b1, 0);
    check("p0_valid", 32'(out_valid), 32'd1);
    check("p0_data", 32'(out_data), 32'h4040);
    check("p0_count", 32'(out_count), 32'd2);
    check("p0_nan", 32'(out_nan), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'h4040);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    pop_check("p0", 16'h4040, 2, 1'b0, 0);

    for (int i = 0; i < 9; i++) begin
      n = int'(vecs[i].n);
      for (int j = 0; j < n; j++) send_beat(vecs[i].d[j], j == n - 1, 0);
      pop_check($sformatf("vec%0d", i), vecs[i].ed, int'(vecs[i].ec), vecs[i].en, 0);
    end

    // Throttled 8-beat packet.
    for (int j = 0; j < 8; j++) send_beat(16'h3F80, j == 7, 3);
    pop_check("thr8", 16'h4100, 8, 1'b0, 2);

    // Back-to-back single-beat packets with out_ready held high.
    out_ready = 1'b1;
    send_beat(16'h3F80, 1'b1, 0);
    check("b2b_a_data", 32'(out_data), 32'h3F80);
    idle = 0;
    while (!in_ready && idle < 10) begin
      idle++;
      @(posedge clk); #1;
    end
    check("b2b_idle", 32'(idle), 32'd1);
    send_beat(16'h4000, 1'b1, 0);
    check("b2b_b_valid", 32'(out_valid), 32'd1);
    check("b2b_b_data", 32'(out_data), 32'h4000);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_drop", 32'(out_valid), 32'd0);

    // Reset mid-packet discards it.
    for (int j = 0; j < 3; j++) send_beat(16'h3F80, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstmid_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send_beat(16'h4000, 1'b1, 0);
    pop_check("after_rst", 16'h4000, 1, 1'b0, 0);

    // Five-beat packet: narrow counter saturates at 3.
    for (int j = 0; j < 5; j++) send_beat(16'h3F80, j == 4, 0);
    check("sat_valid2", 32'(out_valid2), 32'd1);
    check("sat_count2", 32'(out_count2), 32'd3);
    check("sat_data2", 32'(out_data2), 32'h40A0);
    pop_check("sat", 16'h40A0, 5, 1'b0, 0);

    // Random packets against the reference model.
    for (int p = 0; p < 40; p++) begin
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) pk[j] = rnd_val();
      nan = (pk[0][14:7] == 8'hFF) && (pk[0][6:0] != 7'd0);
      acc = nan ? 16'h7FC0 : pk[0];
      for (int j = 1; j < n; j++) begin
        r   = ref_add(acc, pk[j]);
        acc = r[15:0];
        nan = nan | r[16];
      end
      for (int j = 0; j < n; j++) send_beat(pk[j], j == n - 1, 2);
      pop_check($sformatf("rnd%0d", p), acc, n, nan, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
